// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/half/word load-store sequencer for a big-endian word memory,
// with sub-word stores done as read-modify-write and misaligned requests faulted.
module mem_access_ctrl #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, sext_q, sext_d;
  logic [1:0] size_q, size_d, lane_q, lane_d;
  logic [15:0] wd_q, wd_d;
  logic ready_q, ready_d, done_q, done_d, fault_q, fault_d, mem_wen_q, mem_wen_d;
  logic [31:0] rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic illegal;
  logic [31:0] shifted, load_val, mask, ins, merged;
  always_comb begin
    illegal = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    // shifting the addressed lane to the top turns big-endian lane select into a fixed slice
    shifted = mem_rdata << {lane_q, 3'b000};
    load_val = size_q == 2'b00 ? {{24{sext_q & shifted[31]}}, shifted[31:24]} :
               size_q == 2'b01 ? {{16{sext_q & shifted[31]}}, shifted[31:16]} : mem_rdata;
    mask = (size_q == 2'b00 ? 32'hFF00_0000 : 32'hFFFF_0000) >> {lane_q, 3'b000};
    ins = (size_q == 2'b00 ? {wd_q[7:0], 24'h0} : {wd_q, 16'h0}) >> {lane_q, 3'b000};
    merged = (mem_rdata & ~mask) | (ins & mask);
    state_d = state_q;
    we_d = we_q;
    sext_d = sext_q;
    size_d = size_q;
    lane_d = lane_q;
    wd_d = wd_q;
    rdata_d = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: if (req) begin
        we_d = we;
        sext_d = sext;
        size_d = size;
        lane_d = addr[1:0];
        wd_d = wdata[15:0];
        mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
        mem_wdata_d = (we && size == 2'b10) ? wdata : mem_wdata_q;
        state_d = illegal ? DONE : (we && size == 2'b10) ? WRITE : READ;
      end
      READ: begin
        state_d = we_q ? WRITE : DONE;
        mem_wdata_d = we_q ? merged : mem_wdata_q;
        rdata_d = we_q ? rdata_q : load_val;
      end
      WRITE: state_d = DONE;
      DONE: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
    done_d = state_d == DONE;
    mem_wen_d = state_d == WRITE;
    fault_d = state_q == IDLE && req && illegal;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      sext_q <= 1'b0;
      size_q <= 2'b00;
      lane_q <= 2'b00;
      wd_q <= '0;
      ready_q <= 1'b1;
      done_q <= 1'b0;
      fault_q <= 1'b0;
      mem_wen_q <= 1'b0;
      rdata_q <= '0;
      mem_wdata_q <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      sext_q <= sext_d;
      size_q <= size_d;
      lane_q <= lane_d;
      wd_q <= wd_d;
      ready_q <= ready_d;
      done_q <= done_d;
      fault_q <= fault_d;
      mem_wen_q <= mem_wen_d;
      rdata_q <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
      mem_addr_q <= mem_addr_d;
    end
  end
  assign ready = ready_q;
  assign done = done_q;
  assign fault = fault_q;
  assign rdata = rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_wen = mem_wen_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store sequencer between the core's memory stage and the 64-byte big-endian data memory. It accepts one byte, halfword or word request at a time. Sub-word loads get lane selection and sign/zero extension; sub-word stores are done as a read-modify-write, because the memory only writes whole words. Misaligned or illegal requests are flagged without any memory access.

Parameters:
ADDR_W, 6, byte-address width; memory holds 2**ADDR_W bytes. Data width is fixed at 32.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous reset, active-low
req  in  1  request strobe; sampled only while ready=1
we  in  1  1=store, 0=load
size  in  2  00=byte, 01=halfword, 10=word, 11=illegal
sext  in  1  loads only: 1=sign-extend, 0=zero-extend
addr  in  ADDR_W  byte address
wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
ready  out  1  high in IDLE only; a request may be issued
done  out  1  one-cycle pulse: access finished
fault  out  1  valid with done: misaligned access or size=11
rdata  out  32  load result; updated on done, held until the next done
mem_addr  out  ADDR_W  word-aligned address to memory
mem_wen  out  1  memory write enable
mem_wdata  out  32  word written to memory
mem_rdata  in  32  combinational read data from memory (big-endian: byte at base+0 is [31:24])

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=1, done=0, fault=0, rdata=0, mem_wen=0, mem_addr=0, mem_wdata=0. mem_wen drops immediately, even mid-WRITE, so no memory write happens on the next edge.
- On acceptance (IDLE and req=1) the block latches we, size, sext, addr and wdata. base = {addr[ADDR_W-1:2],2'b00} and lane = addr[1:0]. mem_addr is driven with base from the next cycle onward.
- Alignment:
  - Halfword needs addr[0]=0.
  - Word needs addr[1:0]=00.
  - size=11 is always illegal.
  - Any violation goes IDLE->DONE with fault=1, no mem_wen and rdata unchanged.
- States:
  - IDLE: wait for req. Legal load or sub-word store -> READ. Word store -> WRITE. Illegal -> DONE.
  - READ: mem_addr=base; capture mem_rdata into rbuf at the edge. Load -> DONE; sub-word store -> WRITE.
  - WRITE: mem_wen=1 for exactly one cycle, mem_wdata=merged word -> DONE.
  - DONE: done=1 for one cycle, then -> IDLE. fault is 0 except on the illegal path.
- Latency from the accepting edge to done high: fault 1 cycle, load 2, word store 2, sub-word store 3. Throughput is one request per latency+1 cycles; the next req can be accepted in the cycle after DONE.
- Load lane select (big-endian):
  - Byte lane n = rbuf[31-8n -: 8].
  - Half lane 0 = rbuf[31:16], lane 2 = rbuf[15:0].
  - The selected field is extended by sext into rdata. Word loads pass rbuf unchanged.
- Store merge:
  - Byte: rbuf with lane n replaced by wdata[7:0].
  - Half: rbuf with lane 0 or 2 replaced by wdata[15:0].
  - Word: wdata.
  - Unaffected bytes are written back exactly as they were read.
- req while ready=0 is ignored, not queued. Input changes after acceptance have no effect on the access in progress.
- Reset during READ or WRITE aborts the access: no done pulse and no partial write.

Test Plan:
- Reset memory image; byte load addr 0, sext=1 -> done 2 cycles after accept, rdata=0xFFFFFF99; repeat with sext=0 -> 0x00000099.
- Halfword load addr 2, sext=1 -> 0xFFFF8F7E. Word load addr 8 -> 0x017D7840 (25,000,000). Byte load addr 62, sext=1 -> 0xFFFFFF88.
- Byte store 0xAB to addr 13 (word 12 = 0x00000005) -> READ, then WRITE with mem_addr=12, mem_wdata=0x00AB0005, done at 3 cycles. Word load addr 12 then returns 0x00AB0005.
- Word store 0xDEADBEEF to addr 4 -> mem_wen exactly one cycle with no READ, done at 2 cycles. Word load addr 4 returns 0xDEADBEEF.
- Word store to addr 6, halfword load addr 3, and size=11 -> each gives done+fault 1 cycle after accept, mem_wen never high, rdata unchanged.
- Drop rst_n while in WRITE -> mem_wen low immediately, memory word unchanged, no done, ready=1. A req issued during a busy access is ignored (done count = 1).
